// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller.
// State encoding, cause codes and memory-address mux selects.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READ    = 2'd2,
    LOAD    = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_OPC = 2'd0;
  localparam logic [1:0] CAUSE_OVF = 2'd1;
  localparam logic [1:0] CAUSE_DIV = 2'd2;

  localparam logic [2:0] SEL_PC   = 3'd0;
  localparam logic [2:0] SEL_V253 = 3'd2;
  localparam logic [2:0] SEL_V254 = 3'd3;
  localparam logic [2:0] SEL_V255 = 3'd4;

  function automatic logic [2:0] cause_sel(
    input logic [1:0] c
  );
    logic [2:0] s;
    case (c)
      CAUSE_OPC: s = SEL_V253;
      CAUSE_OVF: s = SEL_V254;
      CAUSE_DIV: s = SEL_V255;
      default:   s = SEL_PC;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/exception_ctrl.sv
// Exception sequencer: capture EPC, fetch handler vector, load PC.
// Optional latched cause output enabled by macro EXC_CAUSE_EN.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned MEM_WAIT   = 2,
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        opcode_invalid,
  input  logic        overflow,
  input  logic        div_zero,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  mem_addr_sel,
  output logic [31:0] epc_out,
  output logic        epc_wr,
  output logic [31:0] pc_out,
  output logic        pc_wr,
  output logic        busy,
  output logic [1:0]  exc_cause
);

  localparam int unsigned CW =
    (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam int unsigned CNT_INIT =
    (MEM_WAIT > 0) ? MEM_WAIT - 1 : 0;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [31:0]   epc_q, epc_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   vec_addr;
  logic          req;
  logic [1:0]    cause_d;
  logic          unused_mem_hi;

  assign vec_addr      = {24'b0, mem_data_in[7:0]};
  assign unused_mem_hi = ^mem_data_in[31:8];

  // Fixed priority; lower-priority requests are simply dropped.
  always_comb begin
    req     = opcode_invalid | overflow | div_zero;
    cause_d = CAUSE_DIV;
    if (opcode_invalid) begin
      cause_d = CAUSE_OPC;
    end else if (overflow) begin
      cause_d = CAUSE_OVF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    epc_d   = epc_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = CAPTURE;
          sel_d   = cause_sel(cause_d);
          epc_d   = pc_in - EPC_OFFSET;
        end
      end
      CAPTURE: begin
        if (MEM_WAIT == 0) begin
          state_d = LOAD;
        end else begin
          state_d = READ;
          cnt_d   = CW'(CNT_INIT);
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOAD: begin
        state_d = IDLE;
        sel_d   = SEL_PC;
        pc_d    = vec_addr;
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_PC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sel_q <= SEL_PC;
      epc_q <= '0;
      pc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      epc_q <= epc_d;
      pc_q  <= pc_d;
    end
  end

  // pc_out passes the fetched byte through during LOAD, then holds it.
  always_comb begin
    busy         = (state_q != IDLE);
    epc_wr       = (state_q == CAPTURE);
    pc_wr        = (state_q == LOAD);
    mem_addr_sel = sel_q;
    epc_out      = epc_q;
    pc_out       = pc_wr ? vec_addr : pc_q;
  end

`ifdef EXC_CAUSE_EN
  logic [1:0] cause_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cause_q <= CAUSE_OPC;
    end else if (state_q == IDLE && req) begin
      cause_q <= cause_d;
    end
  end

  assign exc_cause = cause_q;
`else
  assign exc_cause = 2'd0;
`endif

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: MEM_WAIT=2 and MEM_WAIT=0 instances.
// Vector table plus reset and busy-retrigger sequences.
module tb_exception_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        opcode_invalid, overflow, div_zero;
  logic [31:0] pc_in, mem_data_in;

  logic [2:0]  sel_a, sel_b;
  logic [31:0] epc_a, epc_b, pc_a, pc_b;
  logic        epc_wr_a, epc_wr_b, pc_wr_a, pc_wr_b;
  logic        busy_a, busy_b;
  logic [1:0]  cause_a, cause_b;

  int checks = 0;
  int errors = 0;

  exception_ctrl #(.MEM_WAIT(2), .EPC_OFFSET(32'd4)) u_dut_a (
    .clk(clk), .reset(reset),
    .opcode_invalid(opcode_invalid), .overflow(overflow),
    .div_zero(div_zero), .pc_in(pc_in), .mem_data_in(mem_data_in),
    .mem_addr_sel(sel_a), .epc_out(epc_a), .epc_wr(epc_wr_a),
    .pc_out(pc_a), .pc_wr(pc_wr_a), .busy(busy_a),
    .exc_cause(cause_a)
  );

  exception_ctrl #(.MEM_WAIT(0), .EPC_OFFSET(32'd4)) u_dut_b (
    .clk(clk), .reset(reset),
    .opcode_invalid(opcode_invalid), .overflow(overflow),
    .div_zero(div_zero), .pc_in(pc_in), .mem_data_in(mem_data_in),
    .mem_addr_sel(sel_b), .epc_out(epc_b), .epc_wr(epc_wr_b),
    .pc_out(pc_b), .pc_wr(pc_wr_b), .busy(busy_b),
    .exc_cause(cause_b)
  );

  typedef struct {
    logic        opc, ovf, dz;
    logic [31:0] pc, mem;
    logic [2:0]  sel;
    logic [31:0] epc, pcv;
    logic [1:0]  cause;
    bit          hold;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_cause(input logic [1:0] c);
`ifdef EXC_CAUSE_EN
    return c;
`else
    return 2'd0 & c;
`endif
  endfunction

  // 0 idle, 1 capture, 2 read, 3 load, relative to k cycles after request
  function automatic int phase(input int k, input int mw);
    if (k == 1) return 1;
    if (k <= 1 + mw) return 2;
    if (k == 2 + mw) return 3;
    return 0;
  endfunction

  task automatic chk_dut(input string id, input int k, input int mw,
                         input vec_t v, input logic [2:0] sel,
                         input logic [31:0] epc, input logic ew,
                         input logic [31:0] pcv, input logic pw,
                         input logic bsy, input logic [1:0] cs);
    int ph;
    string t;
    ph = phase(k, mw);
    t = $sformatf("%s k%0d", id, k);
    chk({t, " busy"}, 32'(bsy), 32'(ph != 0));
    chk({t, " sel"}, 32'(sel), (ph != 0) ? 32'(v.sel) : 32'd0);
    chk({t, " epc_wr"}, 32'(ew), 32'(ph == 1));
    chk({t, " pc_wr"}, 32'(pw), 32'(ph == 3));
    chk({t, " epc_out"}, epc, v.epc);
    chk({t, " cause"}, 32'(cs), 32'(exp_cause(v.cause)));
    if (ph == 3 || ph == 0) chk({t, " pc_out"}, pcv, v.pcv);
  endtask

  task automatic clear_req();
    opcode_invalid = 1'b0;
    overflow       = 1'b0;
    div_zero       = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int pw_a, pw_b;
    v = tbl[idx];
    pw_a = 0;
    pw_b = 0;
    @(posedge clk); #1;
    opcode_invalid = v.opc;
    overflow       = v.ovf;
    div_zero       = v.dz;
    pc_in          = v.pc;
    mem_data_in    = v.mem;
    @(posedge clk); #1;
    if (!v.hold) clear_req();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (pc_wr_a) pw_a++;
      if (pc_wr_b) pw_b++;
      chk_dut($sformatf("v%0d a", idx), k, 2, v, sel_a, epc_a,
              epc_wr_a, pc_a, pc_wr_a, busy_a, cause_a);
      chk_dut($sformatf("v%0d b", idx), k, 0, v, sel_b, epc_b,
              epc_wr_b, pc_b, pc_wr_b, busy_b, cause_b);
      if (k == 1) pc_in = 32'hDEAD_0000;
      if (k == 2) clear_req();
    end
    chk($sformatf("v%0d a pc_wr count", idx), 32'(pw_a), 32'd1);
    chk($sformatf("v%0d b pc_wr count", idx), 32'(pw_b), 32'd1);
  endtask

  initial begin
    int pw;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h1234_5633,
               3'd2, 32'h0000_000C, 32'h0000_0033, 2'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_007F,
               3'd3, 32'h0000_00FC, 32'h0000_007F, 2'd1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'hFFFF_FFA5,
               3'd4, 32'h0000_1FFC, 32'h0000_00A5, 2'd2, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0002, 32'h0000_0080,
               3'd2, 32'hFFFF_FFFE, 32'h0000_0080, 2'd0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'hAB00_00C3,
               3'd3, 32'h0000_0000, 32'h0000_00C3, 2'd1, 1'b0};

    // Reset with a coincident request: request must be discarded.
    reset          = 1'b1;
    opcode_invalid = 1'b1;
    overflow       = 1'b0;
    div_zero       = 1'b0;
    pc_in          = 32'h0000_0040;
    mem_data_in    = 32'h0000_0011;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 32'(busy_a), 32'd0);
    chk("rst sel", 32'(sel_a), 32'd0);
    chk("rst epc_wr", 32'(epc_wr_a), 32'd0);
    chk("rst pc_wr", 32'(pc_wr_a), 32'd0);
    chk("rst epc_out", epc_a, 32'd0);
    chk("rst pc_out", pc_a, 32'd0);
    chk("rst cause", 32'(cause_a), 32'd0);
    chk("rst b busy", 32'(busy_b), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_req();
    @(negedge clk);
    chk("post rst busy", 32'(busy_a), 32'd0);
    chk("post rst epc_wr", 32'(epc_wr_a), 32'd0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Reset while dut_a is in READ aborts without a pc_wr.
    @(posedge clk); #1;
    opcode_invalid = 1'b1;
    pc_in          = 32'h0000_0300;
    mem_data_in    = 32'h0000_0055;
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    chk("abort capture", 32'(epc_wr_a), 32'd1);
    @(negedge clk);
    chk("abort in read", 32'(busy_a), 32'd1);
    chk("abort read pc_wr", 32'(pc_wr_a), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy", 32'(busy_a), 32'd0);
    chk("abort sel", 32'(sel_a), 32'd0);
    chk("abort pc_wr", 32'(pc_wr_a), 32'd0);
    chk("abort epc_out", epc_a, 32'd0);
    chk("abort pc_out", pc_a, 32'd0);
    chk("abort cause", 32'(cause_a), 32'd0);
    reset = 1'b0;
    pw = 0;
    repeat (4) begin
      @(negedge clk);
      if (pc_wr_a) pw++;
    end
    chk("abort pc_wr count", 32'(pw), 32'd0);
    chk("abort idle", 32'(busy_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 2: cycles the memory address is held before read data is valid.
REQ-002 Parameter EPC_OFFSET, default 4: value subtracted from pc_in to form the EPC.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 opcode_invalid  input  1  exception request, cause 0.
REQ-006 overflow  input  1  exception request, cause 1.
REQ-007 div_zero  input  1  exception request, cause 2.
REQ-008 pc_in  input  32  current PC, already incremented.
REQ-009 mem_data_in  input  32  memory read data; low byte is the handler address.
REQ-010 mem_addr_sel  output  3  select for the memory address mux: 0 selects PC; 2, 3 and 4 select vectors 253, 254 and 255.
REQ-011 epc_out  output  32  value to write into EPC.
REQ-012 epc_wr  output  1  EPC write strobe.
REQ-013 pc_out  output  32  handler address loaded into PC.
REQ-014 pc_wr  output  1  PC write strobe.
REQ-015 busy  output  1  stalls main control while high.
REQ-016 exc_cause  output  2  latched cause code.

Function
REQ-017 FSM states SHALL be IDLE, CAPTURE, READ, LOAD; requests SHALL be sampled only in IDLE.
REQ-018 Priority SHALL be opcode_invalid > overflow > div_zero; simultaneous requests take the highest one, and lower ones are dropped.
REQ-019 Cause 0/1/2 SHALL map to mem_addr_sel 2/3/4 (vectors 253/254/255).
REQ-020 A request in IDLE at cycle N SHALL move the FSM to CAPTURE at N+1, with epc_wr=1 for exactly one cycle and epc_out=pc_in(N)-EPC_OFFSET mod 2^32.
REQ-021 READ SHALL last MEM_WAIT cycles (N+2 .. N+1+MEM_WAIT), holding mem_addr_sel at the vector select; an internal counter SHALL count down from MEM_WAIT-1 to 0.
REQ-022 LOAD SHALL occur at N+2+MEM_WAIT, with pc_wr=1 for one cycle and pc_out={24'b0, mem_data_in[7:0]}, then return to IDLE.
REQ-023 busy SHALL be high in CAPTURE, READ and LOAD, and low in IDLE.
REQ-024 mem_addr_sel SHALL hold the vector select from CAPTURE through LOAD, and be 0 in IDLE.
REQ-025 Requests arriving while busy SHALL be ignored and not queued.
REQ-026 With MEM_WAIT=0, READ SHALL be skipped (CAPTURE goes directly to LOAD).
REQ-027 epc_out and pc_out SHALL hold their last value when their strobe is low.

Reset
REQ-028 Reset SHALL force IDLE with mem_addr_sel=0, epc_wr=0, pc_wr=0, busy=0, epc_out=0, pc_out=0, exc_cause=0 and counter=0.
REQ-029 Reset asserted mid-sequence SHALL abort it at the next edge, with no pc_wr issued.
REQ-030 A request coinciding with reset SHALL be discarded.

Configuration
REQ-031 Macro EXC_CAUSE_EN: when defined, exc_cause SHALL latch the taken cause at CAPTURE and hold it until the next exception or reset.
REQ-032 When EXC_CAUSE_EN is undefined, exc_cause SHALL be constant 0 and no cause register SHALL exist.

Structure
REQ-033 Package exc_pkg SHALL hold the state enum, cause codes (0-2) and mux select constants (SEL_PC=0, SEL_V253=2, SEL_V254=3, SEL_V255=4).
REQ-034 The block SHALL be a single module with no sub-module; the wait counter stays inline.

Verification
REQ-035 MEM_WAIT=2, pc_in=0x10, opcode_invalid pulse at N -> epc_wr at N+1 with epc_out=0x0C; sel=2 from N+1 to N+4; pc_wr at N+4 with pc_out=mem[253] byte.
REQ-036 overflow and div_zero together, mem byte=0x7F -> sel=3, pc_out=0x0000007F, exc_cause=1 (EXC_CAUSE_EN defined).
REQ-037 div_zero re-asserted while busy -> exactly one pc_wr; FSM back in IDLE after LOAD.
REQ-038 reset asserted in READ -> next cycle IDLE, all outputs 0, no pc_wr.
REQ-039 mem_data_in=0xFFFFFFA5 -> pc_out=0x000000A5 (upper bits cleared).
REQ-040 MEM_WAIT=0 -> pc_wr at N+2; EXC_CAUSE_EN undefined -> exc_cause=0 throughout.
